// File: rtl/receive_que_pkg.sv
// rtl/receive_que_pkg.sv - shared word layout, slot states and pointer helper for the receive queue
package receive_que_pkg;

    localparam int WORD_WIDTH    = 9;
    localparam int WORD_LAST_BIT = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } slot_state_e;

    // Pointers carry one extra wrap bit, so the difference modulo 2^ptr_width
    // distinguishes a full store from an empty one.
    function automatic logic [31:0] ptr_occupancy(input logic [31:0] wr_ptr,
                                                  input logic [31:0] rd_ptr,
                                                  input int unsigned ptr_width);
        return (wr_ptr - rd_ptr) & ((32'd1 << ptr_width) - 32'd1);
    endfunction

endpackage

// File: rtl/receive_que_buffer.sv
// rtl/receive_que_buffer.sv - DEPTH x 9 store, one synchronous write port, asynchronous read
module receive_que_buffer
    import receive_que_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WORD_WIDTH-1:0] rd_data_o
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/receive_que_slot.sv
// rtl/receive_que_slot.sv - per-port frame store: commits clean frames, drops bad ones, hands one frame per grant
module receive_que_slot
    import receive_que_pkg::*;
#(
    parameter  int DEPTH      = 64,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_valid,
    input  logic                  rx_data_last,
    input  logic                  rx_data_error,
    output logic                  enable,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  data_enable,
    input  logic                  ready,
    output logic                  frame_dropped,
    output logic [ADDR_WIDTH:0]   frame_count
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] frame_count_q, frame_count_d;
    logic          drop_q, drop_d;
    logic          dropped_q;
    slot_state_e   state_q, state_d;

    logic [PW-1:0] occupancy;
    logic          full;
    logic          wr_en;
    logic          bad_end;
    logic          commit;
    logic          final_accept;

    assign occupancy = PW'(ptr_occupancy(32'(wr_ptr_q), 32'(rd_ptr_q), PW));
    assign full      = (occupancy == PW'(DEPTH));

    receive_que_buffer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buffer (
        .clock_i   (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i ({rx_data_last, rx_data}),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (data)
    );

    // Write side: a frame is either committed whole on its last byte or
    // rewound to commit_ptr, so the reader only ever sees complete frames.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_d       = drop_q;
        wr_en        = 1'b0;
        bad_end      = 1'b0;
        commit       = 1'b0;
        if (rx_data_valid) begin
            if (drop_q || full) begin
                if (rx_data_last) begin
                    bad_end = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end else if (rx_data_last && rx_data_error) begin
                bad_end = 1'b1;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (rx_data_last) begin
                    commit       = 1'b1;
                    commit_ptr_d = wr_ptr_q + PW'(1);
                end
            end
            if (bad_end) begin
                wr_ptr_d = commit_ptr_q;
                drop_d   = 1'b0;
            end
        end
    end

    // Output FSM: S_IDLE between frames forces enable low for a cycle so the
    // arbiter can rotate to another slot.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        enable       = 1'b0;
        data_enable  = 1'b0;
        final_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_count_q != '0) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                enable      = 1'b1;
                data_enable = 1'b1;
                if (ready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (data[WORD_LAST_BIT]) begin
                        final_accept = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_count_d = frame_count_q;
        if (commit && !final_accept) begin
            frame_count_d = frame_count_q + PW'(1);
        end else if (!commit && final_accept) begin
            frame_count_d = frame_count_q - PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            frame_count_q <= '0;
            drop_q        <= 1'b0;
            dropped_q     <= 1'b0;
            state_q       <= S_IDLE;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            frame_count_q <= frame_count_d;
            drop_q        <= drop_d;
            dropped_q     <= bad_end;
            state_q       <= state_d;
        end
    end

    assign frame_dropped = dropped_q;
    assign frame_count   = frame_count_q;

endmodule
